if_id_fifo: RTL and testbench

- Parametrised successor to the single-entry IF/ID pipeline register.
- Decouples fetch from decode with a DEPTH-entry instruction/PC queue.
- Uses valid/ready handshakes on both sides instead of a single hold flag.
- Has a separate flush input that discards queued instructions; decode sees the NOP/zero bubble whenever the queue is empty.

---
 rtl/if_id_fifo.sv | 94 +++++++++
 tb/tb_if_id_fifo.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/if_id_fifo.sv
// if_id_fifo: instruction/PC queue between fetch and decode.
// Holds up to DEPTH {instruction, PC} entries with valid/ready handshakes on
// both sides. Decode sees the NOP bubble (and PC 0) whenever the queue is empty.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   flush_i      discard all queued entries (branch/jump redirect)
//   in_valid_i   fetch offers inst_i/inst_addr_i
//   in_ready_o   queue can accept an entry this cycle (count < DEPTH)
//   inst_i       fetched instruction
//   inst_addr_i  PC of the fetched instruction
//   out_valid_o  head entry valid for decode (count != 0)
//   out_ready_i  decode consumes the head this cycle
//   inst_o       head instruction, or NOP when empty
//   inst_addr_o  head PC, or 0 when empty
//   count_o      number of occupied entries
module if_id_fifo #(
  parameter int unsigned        INST_W = 32,
  parameter int unsigned        ADDR_W = 32,
  parameter int unsigned        DEPTH  = 2,
  parameter logic [INST_W-1:0]  NOP    = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [INST_W-1:0]            inst_i,
  input  logic [ADDR_W-1:0]            inst_addr_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [INST_W-1:0]            inst_o,
  output logic [ADDR_W-1:0]            inst_addr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic push;
  logic pop;

  // Both handshake flags come from registered count only, so there is no
  // combinational path between the upstream and downstream sides.
  assign in_ready_o  = (count < CNT_W'(DEPTH));
  assign out_valid_o = (count != '0);
  assign count_o     = count;

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries beyond count are never presented.
  always_ff @(posedge clk) begin
    if (push && !flush_i && !rst) begin
      inst_mem[wr_ptr] <= inst_i;
      addr_mem[wr_ptr] <= inst_addr_i;
    end
  end

  always_comb begin
    inst_o      = NOP;
    inst_addr_o = '0;
    if (out_valid_o) begin
      inst_o      = inst_mem[rd_ptr];
      inst_addr_o = addr_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_if_id_fifo.sv
// Directed bench for if_id_fifo: a DEPTH=2 instance for reset, single pass,
// fill/full, drain and flush, and a DEPTH=4 instance for a randomly
// back-pressured stream with pointer wrap. A queue-based scoreboard predicts
// every output from the stimulus alone.
module tb_if_id_fifo;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=2 instance signals
  logic        flush2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [31:0] inst2 = '0, addr2 = '0;
  logic        in_ready2, out_valid2;
  logic [31:0] inst_o2, addr_o2;
  logic [1:0]  count2;

  // DEPTH=4 instance signals
  logic        flush4 = 1'b0, in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic [31:0] inst4 = '0, addr4 = '0;
  logic        in_ready4, out_valid4;
  logic [31:0] inst_o4, addr_o4;
  logic [2:0]  count4;

  if_id_fifo #(.INST_W(32), .ADDR_W(32), .DEPTH(2), .NOP(NOP)) u_dut2 (
    .clk(clk), .rst(rst), .flush_i(flush2),
    .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .inst_i(inst2), .inst_addr_i(addr2),
    .out_valid_o(out_valid2), .out_ready_i(out_ready2),
    .inst_o(inst_o2), .inst_addr_o(addr_o2), .count_o(count2)
  );

  if_id_fifo #(.INST_W(32), .ADDR_W(32), .DEPTH(4), .NOP(NOP)) u_dut4 (
    .clk(clk), .rst(rst), .flush_i(flush4),
    .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .inst_i(inst4), .inst_addr_i(addr4),
    .out_valid_o(out_valid4), .out_ready_i(out_ready4),
    .inst_o(inst_o4), .inst_addr_o(addr_o4), .count_o(count4)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned popped4  = 0;

  logic [63:0] q2[$];
  logic [63:0] q4[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the DEPTH=2 instance: drive, compare against the model,
  // advance the model, clock.
  task automatic step2(input string tag, input logic v, input logic [31:0] inst,
                       input logic [31:0] addr, input logic rdy, input logic fl);
    int unsigned sz;
    in_valid2 = v; inst2 = inst; addr2 = addr; out_ready2 = rdy; flush2 = fl;
    sz = q2.size();
    check({tag, ".out_valid"}, 32'(out_valid2), 32'(sz != 0));
    check({tag, ".in_ready"},  32'(in_ready2),  32'(sz < 2));
    check({tag, ".count"},     32'(count2),     sz);
    check({tag, ".inst"},      inst_o2, (sz != 0) ? q2[0][63:32] : NOP);
    check({tag, ".addr"},      addr_o2, (sz != 0) ? q2[0][31:0]  : 32'h0);
    if (fl) q2.delete();
    else begin
      if (sz != 0 && rdy) void'(q2.pop_front());
      if (v && sz < 2) q2.push_back({inst, addr});
    end
    tick();
  endtask

  task automatic step4(input string tag, input logic v, input logic [31:0] inst,
                       input logic [31:0] addr, input logic rdy, output logic taken);
    int unsigned sz;
    in_valid4 = v; inst4 = inst; addr4 = addr; out_ready4 = rdy; flush4 = 1'b0;
    sz = q4.size();
    check({tag, ".out_valid"}, 32'(out_valid4), 32'(sz != 0));
    check({tag, ".in_ready"},  32'(in_ready4),  32'(sz < 4));
    check({tag, ".count"},     32'(count4),     sz);
    check({tag, ".inst"},      inst_o4, (sz != 0) ? q4[0][63:32] : NOP);
    check({tag, ".addr"},      addr_o4, (sz != 0) ? q4[0][31:0]  : 32'h0);
    if (sz != 0 && rdy) begin
      void'(q4.pop_front());
      popped4++;
    end
    taken = v && sz < 4;
    if (taken) q4.push_back({inst, addr});
    tick();
  endtask

  initial begin
    logic taken;
    int unsigned pushed;
    int unsigned guard;

    // Reset for two cycles with fetch offering an instruction.
    rst = 1'b1;
    in_valid2 = 1'b1; inst2 = 32'hdeadbeef; addr2 = 32'h100;
    in_valid4 = 1'b1; inst4 = 32'hdeadbeef; addr4 = 32'h100;
    tick();
    tick();
    rst = 1'b0;
    q2.delete();
    q4.delete();
    in_valid4 = 1'b0;

    // Single pass.
    step2("rst_state", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step2("sp_push",   1'b1, 32'h00500093, 32'h00000004, 1'b1, 1'b0);
    step2("sp_head",   1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step2("sp_bubble", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill to full with decode stalled; C must be refused.
    step2("fill_a",  1'b1, 32'h0000000a, 32'h0, 1'b0, 1'b0);
    step2("fill_b",  1'b1, 32'h0000000b, 32'h4, 1'b0, 1'b0);
    step2("fill_c",  1'b1, 32'h0000000c, 32'h8, 1'b0, 1'b0);
    step2("full_hold", 1'b1, 32'h0000000c, 32'h8, 1'b0, 1'b0);

    // Drain: push/pop at full still rejects C.
    step2("drain_a", 1'b1, 32'h0000000c, 32'h8, 1'b1, 1'b0);
    step2("drain_b", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step2("drained", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Flush with two queued entries and a simultaneous offer.
    step2("fl_p1",   1'b1, 32'h00000111, 32'h20, 1'b0, 1'b0);
    step2("fl_p2",   1'b1, 32'h00000222, 32'h24, 1'b0, 1'b0);
    step2("fl_go",   1'b1, 32'h00100113, 32'h28, 1'b1, 1'b1);
    step2("fl_after",  1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step2("fl_after2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Stream of 20 PCs through DEPTH=4 with random decode back-pressure.
    pushed = 0;
    guard  = 0;
    while (pushed < 20 && guard < 400) begin
      step4("stream", 1'b1, 32'h1000 + pushed, 32'(4 * pushed),
            1'($urandom_range(0, 1)), taken);
      if (taken) pushed++;
      guard++;
    end
    check("stream_pushed", pushed, 32'd20);
    guard = 0;
    while (q4.size() != 0 && guard < 50) begin
      step4("drain4", 1'b0, 32'h0, 32'h0, 1'b1, taken);
      guard++;
    end
    step4("empty4", 1'b0, 32'h0, 32'h0, 1'b0, taken);
    check("stream_popped", popped4, 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
